loadable_down_counter: RTL and testbench

Synchronous, cascadable down-counter with parallel load, dual count enables and terminal-count output. It is the decrementing counterpart of the existing loadable up-counter next-state logic in the lgsynth91 set, and is used for timeouts and divide-by-N chains. Stages can be ripple-cascaded through `tc` into `en_t` to build wider counters.

---
 rtl/lgs_counter_pkg.sv | 27 ++
 rtl/loadable_down_counter_if.sv | 32 +++
 rtl/loadable_down_counter_next.sv | 64 ++++++
 rtl/loadable_down_counter.sv | 94 +++++++++
 tb/tb_loadable_down_counter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lgs_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lgs_counter_pkg
// Description : Shared constants and types for the lgsynth91 counter family.
// Revision    : 1.0 - initial release
// ============================================================================
package lgs_counter_pkg;

    // Underflow behaviour selectors
    localparam int MODE_WRAP   = 0;
    localparam int MODE_RELOAD = 1;
    localparam int MODE_STOP   = 2;

    // Operation selected on a given edge, already resolved by priority
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_CLR   = 2'd1,
        OP_LOAD  = 2'd2,
        OP_COUNT = 2'd3
    } count_op_e;

    function automatic bit mode_is_valid(input int mode);
        return (mode >= MODE_WRAP) && (mode <= MODE_STOP);
    endfunction

endpackage : lgs_counter_pkg
`default_nettype wire

// File: rtl/loadable_down_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : loadable_down_counter_if
// Description : Control/status bundle of one down-counter stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface loadable_down_counter_if #(
    parameter int WIDTH = 4
) ();

    logic             clr;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             en_p;
    logic             en_t;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             uf;
    logic             expired;

    modport master (
        output clr, load, d, en_p, en_t,
        input  q, tc, uf, expired
    );

    modport slave (
        input  clr, load, d, en_p, en_t,
        output q, tc, uf, expired
    );

endinterface : loadable_down_counter_if
`default_nettype wire

// File: rtl/loadable_down_counter_next.sv
`default_nettype none
// ============================================================================
// Module      : down_count_next
// Description : Combinational next-state function of the down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
module down_count_next
    import lgs_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_WRAP
) (
    input  wire logic [WIDTH-1:0] q,
    input  wire logic [WIDTH-1:0] reload_q,
    input  wire logic             clr,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] d,
    input  wire logic             en,
    input  wire logic             halted,
    output logic      [WIDTH-1:0] q_next,
    output logic                  uf_event
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    count_op_e w_op;

    always_comb begin
        w_op = OP_HOLD;
        if (clr) begin
            w_op = OP_CLR;
        end else if (load) begin
            w_op = OP_LOAD;
        end else if (en && !halted) begin
            w_op = OP_COUNT;
        end
    end

    always_comb begin
        q_next   = q;
        uf_event = 1'b0;
        case (w_op)
            OP_CLR:  q_next = '0;
            OP_LOAD: q_next = d;
            OP_COUNT: begin
                if (q != '0) begin
                    q_next = q - c_one;
                end else if (MODE == MODE_WRAP) begin
                    q_next   = '1;
                    uf_event = 1'b1;
                end else if (MODE == MODE_RELOAD) begin
                    // A zero reload value keeps q at 0 and pulses uf every step
                    q_next   = reload_q;
                    uf_event = 1'b1;
                end else begin
                    q_next = '0;
                end
            end
            default: q_next = q;
        endcase
    end

endmodule : down_count_next
`default_nettype wire

// File: rtl/loadable_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : loadable_down_counter
// Description : Cascadable loadable down-counter with terminal count output.
// Revision    : 1.0 - initial release
// ============================================================================
module loadable_down_counter
    import lgs_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_WRAP
) (
    input  wire logic               clk,
    input  wire logic               rst,
    loadable_down_counter_if.slave  bus
);

    if (!mode_is_valid(MODE)) begin : g_bad_mode
        $error("loadable_down_counter: MODE must be 0, 1 or 2");
    end

    if (WIDTH < 2) begin : g_bad_width
        $error("loadable_down_counter: WIDTH must be at least 2");
    end

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_reload_q;
    logic             r_uf;
    logic [WIDTH-1:0] w_q_next;
    logic             w_uf_event;
    logic             w_en;
    logic             w_halted;
    logic             w_step;

    assign w_en   = bus.en_p & bus.en_t;
    assign w_step = w_en & ~w_halted & ~bus.clr & ~bus.load;

    down_count_next #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_next (
        .q        (r_q),
        .reload_q (r_reload_q),
        .clr      (bus.clr),
        .load     (bus.load),
        .d        (bus.d),
        .en       (w_en),
        .halted   (w_halted),
        .q_next   (w_q_next),
        .uf_event (w_uf_event)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q        <= '0;
            r_reload_q <= '0;
            r_uf       <= 1'b0;
        end else begin
            r_q  <= w_q_next;
            r_uf <= w_uf_event;
            if (bus.load && !bus.clr) begin
                r_reload_q <= bus.d;
            end
        end
    end

    if (MODE == MODE_STOP) begin : g_expired
        logic r_expired;

        // Set whenever a count step leaves q at 0, including a step from 0
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_expired <= 1'b0;
            end else if (bus.clr || bus.load) begin
                r_expired <= 1'b0;
            end else if (w_step && (w_q_next == '0)) begin
                r_expired <= 1'b1;
            end
        end

        assign w_halted    = r_expired;
        assign bus.expired = r_expired;
    end else begin : g_no_expired
        assign w_halted    = 1'b0;
        assign bus.expired = 1'b0;
    end

    assign bus.q  = r_q;
    assign bus.uf = r_uf;
    // Cascade path stays combinational so the next stage steps on our wrap edge
    assign bus.tc = bus.en_t & (r_q == '0);

endmodule : loadable_down_counter
`default_nettype wire

// File: tb/tb_loadable_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_loadable_down_counter
// Description : Scoreboard bench for WRAP/RELOAD/STOP stages and a 2-stage cascade.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_loadable_down_counter;
    import lgs_counter_pkg::*;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] q;
        logic       uf;
        logic       ex;
        logic       tc;
    } exp_t;

    typedef struct packed {
        logic       c;
        logic       l;
        logic [7:0] d;
        logic       ep;
        logic       et;
        logic [7:0] q;
        logic       uf;
        logic       ex;
        logic       tc;
    } step_t;

    localparam logic [2:0] c_w = 3'd0;
    localparam logic [2:0] c_r = 3'd1;
    localparam logic [2:0] c_s = 3'd2;
    localparam logic [2:0] c_c = 3'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    loadable_down_counter_if #(.WIDTH(4)) ifc_w  ();
    loadable_down_counter_if #(.WIDTH(4)) ifc_r  ();
    loadable_down_counter_if #(.WIDTH(4)) ifc_s  ();
    loadable_down_counter_if #(.WIDTH(4)) ifc_lo ();
    loadable_down_counter_if #(.WIDTH(4)) ifc_hi ();

    loadable_down_counter #(.WIDTH(4), .MODE(MODE_WRAP))   u_w  (.clk(clk), .rst(rst), .bus(ifc_w));
    loadable_down_counter #(.WIDTH(4), .MODE(MODE_RELOAD)) u_r  (.clk(clk), .rst(rst), .bus(ifc_r));
    loadable_down_counter #(.WIDTH(4), .MODE(MODE_STOP))   u_s  (.clk(clk), .rst(rst), .bus(ifc_s));
    loadable_down_counter #(.WIDTH(4), .MODE(MODE_WRAP))   u_lo (.clk(clk), .rst(rst), .bus(ifc_lo));
    loadable_down_counter #(.WIDTH(4), .MODE(MODE_WRAP))   u_hi (.clk(clk), .rst(rst), .bus(ifc_hi));

    assign ifc_hi.en_p = ifc_lo.en_p;
    assign ifc_hi.en_t = ifc_lo.tc;

    always #5 clk = ~clk;

    function automatic logic [10:0] observe(input logic [2:0] id);
        logic [10:0] r;
        r = '0;
        case (id)
            c_w:     r = {4'h0, ifc_w.q, ifc_w.uf, ifc_w.expired, ifc_w.tc};
            c_r:     r = {4'h0, ifc_r.q, ifc_r.uf, ifc_r.expired, ifc_r.tc};
            c_s:     r = {4'h0, ifc_s.q, ifc_s.uf, ifc_s.expired, ifc_s.tc};
            default: r = {ifc_hi.q, ifc_lo.q, ifc_hi.uf, ifc_hi.expired | ifc_lo.expired, ifc_hi.tc};
        endcase
        return r;
    endfunction

    function automatic step_t mk(input logic c, input logic l, input logic [7:0] dv,
                                 input logic ep, input logic et, input logic [7:0] q,
                                 input logic uf, input logic ex, input logic tc);
        step_t s;
        s = '{c: c, l: l, d: dv, ep: ep, et: et, q: q, uf: uf, ex: ex, tc: tc};
        return s;
    endfunction

    task automatic set_ctl(input logic [2:0] id, input logic c, input logic l,
                           input logic [7:0] dv, input logic ep, input logic et);
        case (id)
            c_w: begin
                ifc_w.clr = c; ifc_w.load = l; ifc_w.d = dv[3:0]; ifc_w.en_p = ep; ifc_w.en_t = et;
            end
            c_r: begin
                ifc_r.clr = c; ifc_r.load = l; ifc_r.d = dv[3:0]; ifc_r.en_p = ep; ifc_r.en_t = et;
            end
            c_s: begin
                ifc_s.clr = c; ifc_s.load = l; ifc_s.d = dv[3:0]; ifc_s.en_p = ep; ifc_s.en_t = et;
            end
            default: begin
                ifc_lo.clr = c; ifc_lo.load = l; ifc_lo.d = dv[3:0]; ifc_lo.en_p = ep; ifc_lo.en_t = et;
                ifc_hi.clr = c; ifc_hi.load = l; ifc_hi.d = dv[7:4];
            end
        endcase
    endtask

    task automatic idle_all();
        for (int i = 0; i < 4; i++) set_ctl(i[2:0], 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [10:0] got;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) sb.push_back('{id: i[2:0], q: 8'h00, uf: 1'b0, ex: 1'b0, tc: 1'b0});
        while (sb.size() != 0) begin
            e = sb.pop_front(); got = observe(e.id); n_tests++;
            if (got !== {e.q, e.uf, e.ex, e.tc}) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got q=%0h uf,ex,tc=%b expected q=%0h uf,ex,tc=%b",
                         e.id, got[10:3], got[2:0], e.q, {e.uf, e.ex, e.tc});
            end
        end
        @(negedge clk); rst = 1'b0;
        set_ctl(c_w, 1'b0, 1'b1, 8'd11, 1'b0, 1'b0);
        set_ctl(c_r, 1'b0, 1'b1, 8'd0,  1'b0, 1'b0);
        set_ctl(c_s, 1'b0, 1'b1, 8'd1,  1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) set_ctl(i[2:0], 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        sb.push_back('{id: c_w, q: 8'd9, uf: 1'b0, ex: 1'b0, tc: 1'b0});
        sb.push_back('{id: c_r, q: 8'd0, uf: 1'b1, ex: 1'b0, tc: 1'b1});
        sb.push_back('{id: c_s, q: 8'd0, uf: 1'b0, ex: 1'b1, tc: 1'b1});
        @(posedge clk); #1;
        while (sb.size() != 0) begin
            e = sb.pop_front(); got = observe(e.id); n_tests++;
            if (got !== {e.q, e.uf, e.ex, e.tc}) begin
                n_fail++;
                $display("FAIL mid_count dut%0d: got q=%0h uf,ex,tc=%b expected q=%0h uf,ex,tc=%b",
                         e.id, got[10:3], got[2:0], e.q, {e.uf, e.ex, e.tc});
            end
        end
        // Reset lands between clock edges; no edge is allowed before the check
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) sb.push_back('{id: i[2:0], q: 8'h00, uf: 1'b0, ex: 1'b0, tc: 1'b1});
        while (sb.size() != 0) begin
            e = sb.pop_front(); got = observe(e.id); n_tests++;
            if (got !== {e.q, e.uf, e.ex, e.tc}) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got q=%0h uf,ex,tc=%b expected q=%0h uf,ex,tc=%b",
                         e.id, got[10:3], got[2:0], e.q, {e.uf, e.ex, e.tc});
            end
        end
        @(negedge clk); rst = 1'b0; idle_all();
    endtask

    task automatic test_wrap();
        step_t       st[$];
        exp_t        e;
        logic [10:0] got;
        st.push_back(mk(0, 1, 8'd2, 0, 0, 8'd2,  0, 0, 0));
        st.push_back(mk(0, 0, 8'd0, 1, 1, 8'd1,  0, 0, 0));
        st.push_back(mk(0, 0, 8'd0, 1, 1, 8'd0,  0, 0, 1));
        st.push_back(mk(0, 0, 8'd0, 1, 1, 8'd15, 1, 0, 0));
        st.push_back(mk(0, 0, 8'd0, 1, 1, 8'd14, 0, 0, 0));
        foreach (st[i]) begin
            @(negedge clk);
            set_ctl(c_w, st[i].c, st[i].l, st[i].d, st[i].ep, st[i].et);
            sb.push_back('{id: c_w, q: st[i].q, uf: st[i].uf, ex: st[i].ex, tc: st[i].tc});
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front(); got = observe(e.id); n_tests++;
                if (got !== {e.q, e.uf, e.ex, e.tc}) begin
                    n_fail++;
                    $display("FAIL wrap step%0d: got q=%0h uf,ex,tc=%b expected q=%0h uf,ex,tc=%b",
                             i, got[10:3], got[2:0], e.q, {e.uf, e.ex, e.tc});
                end
            end
        end
    endtask

    task automatic test_reload();
        step_t       st[$];
        exp_t        e;
        logic [10:0] got;
        logic [7:0]  qs[8];
        qs = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
        st.push_back(mk(0, 1, 8'd3, 0, 0, 8'd3, 0, 0, 0));
        for (int k = 0; k < 8; k++) st.push_back(mk(0, 0, 8'd0, 1, 1, qs[k], (k == 3) || (k == 7), 0, qs[k] == 8'd0));
        st.push_back(mk(1, 0, 8'd0, 0, 0, 8'd0, 0, 0, 0));
        st.push_back(mk(0, 0, 8'd0, 1, 1, 8'd3, 1, 0, 0));
        st.push_back(mk(1, 1, 8'd9, 1, 1, 8'd0, 0, 0, 1));
        st.push_back(mk(0, 0, 8'd0, 1, 1, 8'd3, 1, 0, 0));
        st.push_back(mk(0, 0, 8'd0, 0, 0, 8'd3, 0, 0, 0));
        foreach (st[i]) begin
            @(negedge clk);
            set_ctl(c_r, st[i].c, st[i].l, st[i].d, st[i].ep, st[i].et);
            sb.push_back('{id: c_r, q: st[i].q, uf: st[i].uf, ex: st[i].ex, tc: st[i].tc});
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front(); got = observe(e.id); n_tests++;
                if (got !== {e.q, e.uf, e.ex, e.tc}) begin
                    n_fail++;
                    $display("FAIL reload step%0d: got q=%0h uf,ex,tc=%b expected q=%0h uf,ex,tc=%b",
                             i, got[10:3], got[2:0], e.q, {e.uf, e.ex, e.tc});
                end
            end
        end
    endtask

    task automatic test_stop();
        step_t       st[$];
        exp_t        e;
        logic [10:0] got;
        st.push_back(mk(0, 1, 8'd2, 0, 0, 8'd2, 0, 0, 0));
        st.push_back(mk(0, 0, 8'd0, 1, 1, 8'd1, 0, 0, 0));
        for (int k = 0; k < 4; k++) st.push_back(mk(0, 0, 8'd0, 1, 1, 8'd0, 0, 1, 1));
        st.push_back(mk(0, 1, 8'd5, 0, 0, 8'd5, 0, 0, 0));
        st.push_back(mk(0, 1, 8'd0, 0, 0, 8'd0, 0, 0, 0));
        st.push_back(mk(0, 0, 8'd0, 1, 1, 8'd0, 0, 1, 1));
        st.push_back(mk(1, 0, 8'd0, 0, 0, 8'd0, 0, 0, 0));
        foreach (st[i]) begin
            @(negedge clk);
            set_ctl(c_s, st[i].c, st[i].l, st[i].d, st[i].ep, st[i].et);
            sb.push_back('{id: c_s, q: st[i].q, uf: st[i].uf, ex: st[i].ex, tc: st[i].tc});
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front(); got = observe(e.id); n_tests++;
                if (got !== {e.q, e.uf, e.ex, e.tc}) begin
                    n_fail++;
                    $display("FAIL stop step%0d: got q=%0h uf,ex,tc=%b expected q=%0h uf,ex,tc=%b",
                             i, got[10:3], got[2:0], e.q, {e.uf, e.ex, e.tc});
                end
            end
        end
    endtask

    task automatic test_priority();
        step_t       st[$];
        exp_t        e;
        logic [10:0] got;
        st.push_back(mk(1, 1, 8'd7, 1, 1, 8'd0,  0, 0, 1));
        st.push_back(mk(0, 1, 8'd7, 1, 1, 8'd7,  0, 0, 0));
        st.push_back(mk(0, 0, 8'd0, 1, 0, 8'd7,  0, 0, 0));
        st.push_back(mk(1, 0, 8'd0, 0, 0, 8'd0,  0, 0, 0));
        st.push_back(mk(0, 0, 8'd0, 1, 0, 8'd0,  0, 0, 0));
        st.push_back(mk(0, 0, 8'd0, 0, 1, 8'd0,  0, 0, 1));
        st.push_back(mk(0, 0, 8'd0, 1, 1, 8'd15, 1, 0, 0));
        st.push_back(mk(0, 0, 8'd0, 0, 0, 8'd15, 0, 0, 0));
        foreach (st[i]) begin
            @(negedge clk);
            set_ctl(c_w, st[i].c, st[i].l, st[i].d, st[i].ep, st[i].et);
            sb.push_back('{id: c_w, q: st[i].q, uf: st[i].uf, ex: st[i].ex, tc: st[i].tc});
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front(); got = observe(e.id); n_tests++;
                if (got !== {e.q, e.uf, e.ex, e.tc}) begin
                    n_fail++;
                    $display("FAIL priority step%0d: got q=%0h uf,ex,tc=%b expected q=%0h uf,ex,tc=%b",
                             i, got[10:3], got[2:0], e.q, {e.uf, e.ex, e.tc});
                end
            end
        end
    endtask

    task automatic test_cascade();
        step_t       st[$];
        exp_t        e;
        logic [10:0] got;
        logic [7:0]  v;
        st.push_back(mk(0, 1, 8'h10, 0, 0, 8'h10, 0, 0, 0));
        for (int k = 0; k <= 16; k++) begin
            v = 8'h0F - 8'(k);
            st.push_back(mk(0, 0, 8'h00, 1, 1, v, k == 16, 0, v == 8'h00));
        end
        st.push_back(mk(0, 0, 8'h00, 0, 0, 8'hFF, 0, 0, 0));
        foreach (st[i]) begin
            @(negedge clk);
            set_ctl(c_c, st[i].c, st[i].l, st[i].d, st[i].ep, st[i].et);
            sb.push_back('{id: c_c, q: st[i].q, uf: st[i].uf, ex: st[i].ex, tc: st[i].tc});
            @(posedge clk); #1;
            while (sb.size() != 0) begin
                e = sb.pop_front(); got = observe(e.id); n_tests++;
                if (got !== {e.q, e.uf, e.ex, e.tc}) begin
                    n_fail++;
                    $display("FAIL cascade step%0d: got q=%0h uf,ex,tc=%b expected q=%0h uf,ex,tc=%b",
                             i, got[10:3], got[2:0], e.q, {e.uf, e.ex, e.tc});
                end
            end
        end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_wrap();
        test_reload();
        test_stop();
        test_priority();
        test_cascade();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_loadable_down_counter
`default_nettype wire
